// File: rtl/song_sequencer_if.sv
// Bundle between the song sequencer and its surroundings: transport control, song ROM port and note/tick outputs.
// The master drives start/pause and returns ROM data; the slave is the sequencer.
interface song_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              pause;
    logic [33:0]       rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic              tick;
    logic              note_trigger;
    logic [17:0]       note_data;
    logic [15:0]       song_time;
    logic              playing;
    logic              done;

    modport master (
        output start, pause, rom_data,
        input  rom_addr, tick, note_trigger, note_data, song_time, playing, done
    );

    modport slave (
        input  start, pause, rom_data,
        output rom_addr, tick, note_trigger, note_data, song_time, playing, done
    );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a time-stamped song ROM, emitting each note payload once song time reaches its entry time.
// Song time advances by one on every tick, produced by a divider that only runs while playing and not paused.
module song_sequencer #(
    parameter int TICK_DIV = 650000,
    parameter int ADDR_W   = 12
) (
    input  logic                clk,
    input  logic                reset,
    song_sequencer_if.slave     bus
);
    localparam int                DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE  = DIV_W'(TICK_DIV - 2);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [15:0]       END_MARK = 16'hFFFF;
    localparam logic [15:0]       TIME_MAX = 16'hFFFE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [DIV_W-1:0]   divider_r;
    logic [15:0]        song_time_r;
    logic [15:0]        entry_time_r;
    logic [17:0]        entry_note_r;
    logic [17:0]        note_data_r;
    logic               tick_r;
    logic               note_trigger_r;
    logic               playing_r;
    logic               done_r;
    logic               end_s;
    logic               advance_s;

    // The divider freezes on the edge that ends the song so no tick coincides with DONE.
    assign end_s     = ((state_r == WAIT) && (entry_time_r == END_MARK)) ||
                       ((state_r == EMIT) && (rom_addr_r == ADDR_MAX));
    assign advance_s = playing_r && !bus.pause && !end_s;

    // Sequencer FSM, tick divider and song clock, all with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            rom_addr_r     <= '0;
            divider_r      <= '0;
            song_time_r    <= 16'h0000;
            entry_time_r   <= 16'h0000;
            entry_note_r   <= 18'h00000;
            note_data_r    <= 18'h00000;
            tick_r         <= 1'b0;
            note_trigger_r <= 1'b0;
            playing_r      <= 1'b0;
            done_r         <= 1'b0;
        end else if (bus.start) begin
            state_r        <= FETCH;
            rom_addr_r     <= '0;
            divider_r      <= '0;
            song_time_r    <= 16'h0000;
            tick_r         <= 1'b0;
            note_trigger_r <= 1'b0;
            playing_r      <= 1'b1;
            done_r         <= 1'b0;
        end else begin
            tick_r         <= 1'b0;
            note_trigger_r <= 1'b0;
            // Tick fires on the step into the terminal count, giving the first tick TICK_DIV cycles after start.
            if (advance_s) begin
                divider_r <= (divider_r == DIV_LAST) ? '0 : divider_r + DIV_W'(1);
                if (divider_r == DIV_PRE) begin
                    tick_r <= 1'b1;
                    if (song_time_r != TIME_MAX) begin
                        song_time_r <= song_time_r + 16'd1;
                    end
                end
            end
            case (state_r)
                IDLE: state_r <= IDLE;
                FETCH: state_r <= LOAD;
                LOAD: begin
                    entry_time_r <= bus.rom_data[33:18];
                    entry_note_r <= bus.rom_data[17:0];
                    state_r      <= WAIT;
                end
                WAIT: begin
                    if (entry_time_r == END_MARK) begin
                        state_r   <= DONE;
                        playing_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else if (song_time_r >= entry_time_r) begin
                        state_r        <= EMIT;
                        note_data_r    <= entry_note_r;
                        note_trigger_r <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                EMIT: begin
                    if (rom_addr_r == ADDR_MAX) begin
                        state_r   <= DONE;
                        playing_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        rom_addr_r <= rom_addr_r + ADDR_W'(1);
                        state_r    <= FETCH;
                    end
                end
                DONE: state_r <= DONE;
                default: begin
                    state_r   <= IDLE;
                    playing_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr     = rom_addr_r;
    assign bus.tick         = tick_r;
    assign bus.note_trigger = note_trigger_r;
    assign bus.note_data    = note_data_r;
    assign bus.song_time    = song_time_r;
    assign bus.playing      = playing_r;
    assign bus.done         = done_r;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4, ADDR_W=4; cycle numbers count edges after the start cycle (start edge = 1).
// Trigger, tick and done times are logged per run and compared against hand-derived schedules.
module tb_song_sequencer;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 4;
    localparam logic [17:0] NA = 18'h0A0A0;
    localparam logic [17:0] NB = 18'h0B0B0;
    localparam logic [17:0] NC = 18'h0C0C0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    song_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    song_sequencer #(.TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [33:0] rom [16];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int failures = 0;
    int rel;
    int done_at;
    int trig_q[$];
    logic [17:0] note_q[$];
    int tick_q[$];

    task automatic load_basic_rom();
        for (int i = 0; i < 16; i++) rom[i] = {16'hFFFF, 18'h3FFFF};
        rom[0] = {16'd0, NA};
        rom[1] = {16'd0, NB};
        rom[2] = {16'd2, NC};
    endtask

    task automatic clear_log();
        trig_q.delete();
        note_q.delete();
        tick_q.delete();
        done_at = -1;
        rel = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rel++;
        if (bus.note_trigger) begin
            trig_q.push_back(rel);
            note_q.push_back(bus.note_data);
        end
        if (bus.tick) tick_q.push_back(rel);
        if (bus.done && done_at < 0) done_at = rel;
    endtask

    task automatic go();
        clear_log();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [42:0] outs;
        repeat (2) step();
        outs = {bus.rom_addr, bus.tick, bus.note_trigger, bus.note_data, bus.song_time, bus.playing, bus.done};
        checks++;
        if (outs !== 43'd0) begin failures++; $display("FAIL reset_outputs: got %0h expected 0", outs); end
        reset = 1'b1;
        clear_log();
        repeat (6) step();
        checks++;
        if ({bus.playing, bus.done} !== 2'b00 || tick_q.size() != 0 || trig_q.size() != 0) begin
            failures++;
            $display("FAIL idle_after_reset: playing=%0b done=%0b ticks=%0d trigs=%0d expected all 0",
                     bus.playing, bus.done, tick_q.size(), trig_q.size());
        end
    endtask

    task automatic test_basic();
        load_basic_rom();
        go();
        checks++;
        if ({bus.playing, bus.done, bus.rom_addr} !== {1'b1, 1'b0, 4'd0}) begin
            failures++; $display("FAIL start_state: playing=%0b done=%0b addr=%0d expected 1 0 0", bus.playing, bus.done, bus.rom_addr);
        end
        repeat (23) step();
        checks++;
        if (trig_q.size() != 3 || trig_q[0] != 4 || trig_q[1] != 8 || trig_q[2] != 12) begin
            failures++; $display("FAIL basic_trigger_cycles: got n=%0d %p expected 4 8 12", trig_q.size(), trig_q);
        end
        checks++;
        if (note_q.size() != 3 || note_q[0] !== NA || note_q[1] !== NB || note_q[2] !== NC) begin
            failures++; $display("FAIL basic_notes: got %p expected A B C", note_q);
        end
        checks++;
        if (tick_q.size() != 3 || tick_q[0] != 4 || tick_q[1] != 8 || tick_q[2] != 12) begin
            failures++; $display("FAIL basic_ticks: got %p expected 4 8 12", tick_q);
        end
        checks++;
        if (done_at != 16) begin failures++; $display("FAIL basic_done_cycle: got %0d expected 16", done_at); end
        checks++;
        if ({bus.playing, bus.done, bus.song_time, bus.rom_addr} !== {1'b0, 1'b1, 16'd3, 4'd3}) begin
            failures++;
            $display("FAIL basic_done_state: playing=%0b done=%0b time=%0d addr=%0d expected 0 1 3 3",
                     bus.playing, bus.done, bus.song_time, bus.rom_addr);
        end
    endtask

    task automatic test_pause();
        load_basic_rom();
        go();
        repeat (3) step();
        bus.pause = 1'b1;
        repeat (20) step();
        checks++;
        if (bus.song_time !== 16'd1) begin failures++; $display("FAIL pause_frozen_time: got %0d expected 1", bus.song_time); end
        bus.pause = 1'b0;
        repeat (16) step();
        checks++;
        if (trig_q.size() != 3 || trig_q[0] != 4 || trig_q[1] != 8 || trig_q[2] != 29) begin
            failures++; $display("FAIL pause_trigger_cycles: got %p expected 4 8 29", trig_q);
        end
        checks++;
        if (tick_q.size() != 3 || tick_q[0] != 4 || tick_q[1] != 28 || tick_q[2] != 32) begin
            failures++; $display("FAIL pause_ticks: got %p expected 4 28 32", tick_q);
        end
        checks++;
        if (done_at != 33) begin failures++; $display("FAIL pause_done_cycle: got %0d expected 33", done_at); end
    endtask

    task automatic test_restart();
        load_basic_rom();
        go();
        repeat (3) step();
        bus.pause = 1'b1;
        repeat (10) step();
        bus.start = 1'b1;
        bus.pause = 1'b0;
        step();
        bus.start = 1'b0;
        checks++;
        if ({bus.rom_addr, bus.song_time, bus.done, bus.playing, bus.note_trigger} !== {4'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL restart_state: addr=%0d time=%0d done=%0b playing=%0b trig=%0b expected 0 0 0 1 0",
                     bus.rom_addr, bus.song_time, bus.done, bus.playing, bus.note_trigger);
        end
        repeat (3) step();
        checks++;
        if (trig_q.size() != 3 || trig_q[2] != 18 || note_q[2] !== NA) begin
            failures++; $display("FAIL restart_reemit: got %p notes %p expected third trigger at 18 with A", trig_q, note_q);
        end
    endtask

    task automatic test_start_pause();
        load_basic_rom();
        bus.pause = 1'b1;
        go();
        repeat (19) step();
        checks++;
        if (tick_q.size() != 0 || bus.song_time !== 16'd0) begin
            failures++; $display("FAIL start_pause_hold: ticks=%0d time=%0d expected 0 0", tick_q.size(), bus.song_time);
        end
        checks++;
        if (trig_q.size() != 2 || trig_q[0] != 4 || trig_q[1] != 8 || note_q[0] !== NA || note_q[1] !== NB) begin
            failures++; $display("FAIL start_pause_due: got %p notes %p expected 4 8 with A B", trig_q, note_q);
        end
        bus.pause = 1'b0;
        repeat (10) step();
        checks++;
        if (tick_q.size() < 2 || tick_q[0] != 23 || tick_q[1] != 27) begin
            failures++; $display("FAIL start_pause_resume_ticks: got %p expected 23 27", tick_q);
        end
        checks++;
        if (trig_q.size() != 3 || trig_q[2] != 28 || note_q[2] !== NC) begin
            failures++; $display("FAIL start_pause_late_c: got %p expected third trigger at 28", trig_q);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) rom[i] = {16'd0, 18'(i + 256)};
        go();
        repeat (75) step();
        checks++;
        if (trig_q.size() != 16) begin failures++; $display("FAIL wrap_count: got %0d expected 16", trig_q.size()); end
        for (int i = 0; i < 16 && i < trig_q.size(); i++) begin
            checks++;
            if (trig_q[i] != 4 + 4 * i || note_q[i] !== 18'(i + 256)) begin
                failures++;
                $display("FAIL wrap_entry_%0d: cycle %0d note %0h expected cycle %0d note %0h",
                         i, trig_q[i], note_q[i], 4 + 4 * i, i + 256);
            end
        end
        checks++;
        if (done_at != 65 || bus.rom_addr !== 4'd15 || bus.playing !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done: done_at=%0d addr=%0d playing=%0b expected 65 15 0", done_at, bus.rom_addr, bus.playing);
        end
    endtask

    task automatic test_reset_mid();
        logic [42:0] outs;
        load_basic_rom();
        go();
        repeat (10) step();
        checks++;
        if ({bus.playing, bus.song_time, bus.rom_addr} !== {1'b1, 16'd2, 4'd2}) begin
            failures++; $display("FAIL mid_pre_state: playing=%0b time=%0d addr=%0d expected 1 2 2",
                                 bus.playing, bus.song_time, bus.rom_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        outs = {bus.rom_addr, bus.tick, bus.note_trigger, bus.note_data, bus.song_time, bus.playing, bus.done};
        checks++;
        if (outs !== 43'd0) begin failures++; $display("FAIL mid_async_reset: got %0h expected 0", outs); end
        repeat (2) step();
        reset = 1'b1;
        clear_log();
        repeat (20) step();
        checks++;
        if (tick_q.size() != 0 || trig_q.size() != 0 || bus.playing !== 1'b0) begin
            failures++; $display("FAIL mid_stays_idle: ticks=%0d trigs=%0d playing=%0b expected 0 0 0",
                                 tick_q.size(), trig_q.size(), bus.playing);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        load_basic_rom();
        test_reset();
        test_basic();
        test_pause();
        test_restart();
        test_start_pause();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
